// File: rtl/student_fir_mac_seq_if.sv
// Signal bundle for the sequential FIR MAC: sample handshake, sample-RAM ports,
// coefficient port and result handshake. master = filter block, slave = its environment.
interface student_fir_mac_seq_if #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16,
  parameter int NumTaps   = 64
);
  localparam int AccWidth = 2*DataSize + $clog2(NumTaps) + 1;

  logic                          sample_valid_i;
  logic signed [DataSize-1:0]    sample_i;
  logic                          sample_ready_o;
  logic                          ena_o;
  logic                          wea_o;
  logic        [AddrWidth-1:0]   addra_o;
  logic signed [DataSize-1:0]    dia_o;
  logic                          enb_o;
  logic        [AddrWidth-1:0]   addrb_o;
  logic signed [DataSize-1:0]    dob_i;
  logic                          coef_en_o;
  logic        [AddrWidth-1:0]   coef_addr_o;
  logic signed [DataSize-1:0]    coef_i;
  logic signed [AccWidth-1:0]    y_o;
  logic                          y_valid_o;
  logic                          y_ready_i;
  logic                          busy_o;

  modport master (
    input  sample_valid_i, sample_i, dob_i, coef_i, y_ready_i,
    output sample_ready_o, ena_o, wea_o, addra_o, dia_o, enb_o, addrb_o,
           coef_en_o, coef_addr_o, y_o, y_valid_o, busy_o
  );

  modport slave (
    output sample_valid_i, sample_i, dob_i, coef_i, y_ready_i,
    input  sample_ready_o, ena_o, wea_o, addra_o, dia_o, enb_o, addrb_o,
           coef_en_o, coef_addr_o, y_o, y_valid_o, busy_o
  );
endinterface

// File: rtl/student_fir_mac_seq.sv
// Sequential FIR: one sample in, NumTaps multiply-accumulates over an external
// sample ring RAM and coefficient memory, one full-precision result out.
module student_fir_mac_seq #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16,
  parameter int NumTaps   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  student_fir_mac_seq_if.master bus
);
  localparam int AccWidth = 2*DataSize + $clog2(NumTaps) + 1;
  localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(NumTaps - 1);

  if ((NumTaps < 1) || (NumTaps > (2**AddrWidth))) begin : g_taps_range
    $error("student_fir_mac_seq: NumTaps must lie in 1..2**AddrWidth");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                       r_state, w_state_nxt;
  logic        [AddrWidth-1:0]  r_k, w_k_nxt, r_wptr;
  logic        [AddrWidth-1:0]  r_addra, r_addrb, r_coef_addr;
  logic signed [DataSize-1:0]   r_dia;
  logic signed [2*DataSize-1:0] w_prod;
  logic signed [AccWidth-1:0]   r_acc, r_y, w_acc_sum;
  logic                         r_mac_vld;
  logic                         r_ready, r_ena, r_wea, r_enb, r_coef_en, r_y_valid, r_busy;
  logic                         w_accept, w_release;

  assign w_accept  = (r_state == S_IDLE) && r_ready && bus.sample_valid_i;
  assign w_release = (r_state == S_OUT) && r_y_valid && bus.y_ready_i;

  // Next state and tap index
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WRITE;
        else          w_state_nxt = S_IDLE;
      end
      S_WRITE: begin
        w_state_nxt = S_RUN;
        w_k_nxt     = '0;
      end
      S_RUN: begin
        if (r_k == LastTap) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
          w_k_nxt     = r_k + AddrWidth'(1);
        end
      end
      S_DRAIN: w_state_nxt = S_OUT;
      S_OUT: begin
        if (w_release) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Product of the RAM and coefficient words returned for the previous issue
  always_comb begin
    w_prod    = (2*DataSize)'(bus.dob_i) * (2*DataSize)'(bus.coef_i);
    w_acc_sum = r_acc + AccWidth'(w_prod);
  end

  // State and registered outputs, decoded from the state being entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_wptr      <= '0;
      r_ready     <= 1'b0;
      r_ena       <= 1'b0;
      r_wea       <= 1'b0;
      r_enb       <= 1'b0;
      r_coef_en   <= 1'b0;
      r_addra     <= '0;
      r_addrb     <= '0;
      r_coef_addr <= '0;
      r_dia       <= '0;
      r_y_valid   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_ena       <= (w_state_nxt == S_WRITE);
      r_wea       <= (w_state_nxt == S_WRITE);
      r_enb       <= (w_state_nxt == S_RUN);
      r_coef_en   <= (w_state_nxt == S_RUN);
      r_addra     <= r_wptr;
      r_addrb     <= r_wptr - w_k_nxt;
      r_coef_addr <= w_k_nxt;
      r_y_valid   <= (w_state_nxt == S_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_accept) r_dia <= bus.sample_i;
      if (r_state == S_DRAIN) r_wptr <= r_wptr + AddrWidth'(1);
    end
  end

  // Accumulator: read data lags each issue by one cycle, so valid follows enb_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc     <= '0;
      r_y       <= '0;
      r_mac_vld <= 1'b0;
    end else begin
      r_mac_vld <= r_enb;
      if (r_state == S_WRITE) r_acc <= '0;
      else if (r_mac_vld)     r_acc <= w_acc_sum;
      if (r_state == S_DRAIN) r_y <= w_acc_sum;
    end
  end

  assign bus.sample_ready_o = r_ready;
  assign bus.ena_o          = r_ena;
  assign bus.wea_o          = r_wea;
  assign bus.addra_o        = r_addra;
  assign bus.dia_o          = r_dia;
  assign bus.enb_o          = r_enb;
  assign bus.addrb_o        = r_addrb;
  assign bus.coef_en_o      = r_coef_en;
  assign bus.coef_addr_o    = r_coef_addr;
  assign bus.y_o            = r_y;
  assign bus.y_valid_o      = r_y_valid;
  assign bus.busy_o         = r_busy;
endmodule
